maze_dfs_solver: RTL and testbench

Parametrised depth-first maze solver, the next generation of the fixed 16x16 rat-in-maze block. It walks a rectangular grid from (0,0) to (2^X_W-1, 2^Y_W-1), reading wall bits from an external synchronous maze memory. It tracks visited cells internally and keeps the path on a move stack. On request it replays the found path one move per cycle to the downstream display/logging logic.

---
 rtl/maze_pkg.sv | 39 +++
 rtl/maze_move_stack.sv | 45 ++++
 rtl/maze_dfs_solver.sv | 221 ++++++++++++++++++++++
 tb/tb_maze_dfs_solver.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared types for the depth-first maze solver: direction codes, controller
// states and the per-direction coordinate delta.
package maze_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WAIT,
    BACK,
    DONE,
    FAIL,
    REPLAY
  } state_t;

  // Two's-complement deltas in {-1, 0, +1}; callers sign-extend to their width.
  typedef struct packed {
    logic [1:0] dx;
    logic [1:0] dy;
  } delta_t;

  function automatic delta_t dir_delta(input logic [1:0] dir);
    delta_t d;
    d.dx = 2'b00;
    d.dy = 2'b00;
    case (dir)
      DIR_UP:    d.dy = 2'b11;
      DIR_RIGHT: d.dx = 2'b01;
      DIR_LEFT:  d.dx = 2'b11;
      default:   d.dy = 2'b01;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/maze_move_stack.sv
// LIFO of 2-bit moves: synchronous push, combinational top-of-stack and
// indexed read port used by path replay.
module maze_move_stack #(
  parameter int DEPTH = 256,
  parameter int SP_W  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            push,
  input  logic            pop,
  input  logic [1:0]      push_data,
  input  logic [SP_W-1:0] rd_idx,
  output logic [1:0]      rd_data,
  output logic [1:0]      top_data,
  output logic            full,
  output logic            empty,
  output logic [SP_W:0]   sp
);

  logic [1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[sp[SP_W-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + (SP_W+1)'(1);
    end else if (pop && !empty) begin
      sp <= sp - (SP_W+1)'(1);
    end
  end

  assign full     = (sp == (SP_W+1)'(DEPTH));
  assign empty    = (sp == '0);
  // Low bits of sp-1 wrap correctly when the stack is exactly full.
  assign top_data = mem[sp[SP_W-1:0] - SP_W'(1)];
  assign rd_data  = mem[rd_idx];

endmodule

// File: rtl/maze_dfs_solver.sv
// Depth-first maze solver from (0,0) to the far corner with move-stack replay.
// Optional MAZE_STEP_CNT_EN adds a saturating 16-bit steps output.
module maze_dfs_solver
  import maze_pkg::*;
#(
  parameter int X_W         = 4,
  parameter int Y_W         = 4,
  parameter int STACK_DEPTH = 256,
  parameter int SP_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               run,
  output logic               mem_rd,
  output logic [X_W+Y_W-1:0] mem_addr,
  input  logic               mem_dout,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic               overflow,
  output logic [1:0]         move,
  output logic               move_valid,
  output logic [X_W-1:0]     x_o,
  output logic [Y_W-1:0]     y_o,
  output logic [SP_W:0]      path_len
`ifdef MAZE_STEP_CNT_EN
  ,
  output logic [15:0]        steps
`endif
);

  localparam int A_W   = X_W + Y_W;
  localparam int CELLS = 1 << A_W;

  state_t           state, state_nx;
  logic [X_W-1:0]   pos_x, cand_x, back_x;
  logic [Y_W-1:0]   pos_y, cand_y, back_y;
  logic [X_W:0]     cand_xw;
  logic [Y_W:0]     cand_yw;
  logic [1:0]       dir, top_data, rd_data;
  logic [A_W-1:0]   cand_addr;
  logic [CELLS-1:0] visited;
  logic [SP_W-1:0]  rep_idx;
  logic [SP_W:0]    sp;
  logic             ovf_q, full, empty, cand_blocked, cand_goal, rep_last;
  logic             do_clear, do_adv, do_push, do_pop, set_ovf, rep_start;
  delta_t           fwd_d, back_d;

  // The extra top bit of the candidate sum flags both -1 and 2^W, i.e. off-grid.
  always_comb begin
    fwd_d   = dir_delta(dir);
    back_d  = dir_delta(top_data);
    cand_xw = {1'b0, pos_x} + (X_W+1)'($signed(fwd_d.dx));
    cand_yw = {1'b0, pos_y} + (Y_W+1)'($signed(fwd_d.dy));
    back_x  = pos_x - X_W'($signed(back_d.dx));
    back_y  = pos_y - Y_W'($signed(back_d.dy));
  end

  assign cand_x       = cand_xw[X_W-1:0];
  assign cand_y       = cand_yw[Y_W-1:0];
  assign cand_addr    = {cand_y, cand_x};
  assign cand_blocked = cand_xw[X_W] | cand_yw[Y_W] | visited[cand_addr];
  assign cand_goal    = (&cand_x) & (&cand_y);
  assign rep_last     = (((SP_W+1)'(rep_idx) + (SP_W+1)'(1)) == sp);

  maze_move_stack #(
    .DEPTH(STACK_DEPTH),
    .SP_W (SP_W)
  ) u_stack (
    .clk      (clk),
    .rst      (rst),
    .clear    (do_clear),
    .push     (do_push),
    .pop      (do_pop),
    .push_data(dir),
    .rd_idx   (rep_idx),
    .rd_data  (rd_data),
    .top_data (top_data),
    .full     (full),
    .empty    (empty),
    .sp       (sp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    mem_rd    = 1'b0;
    do_clear  = 1'b0;
    do_adv    = 1'b0;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    set_ovf   = 1'b0;
    rep_start = 1'b0;
    case (state)
      IDLE, FAIL: begin
        if (start) begin
          do_clear = 1'b1;
          state_nx = CHECK;
        end
      end
      DONE: begin
        if (start) begin
          do_clear = 1'b1;
          state_nx = CHECK;
        end else if (run && !empty) begin
          rep_start = 1'b1;
          state_nx  = REPLAY;
        end
      end
      CHECK: begin
        if (cand_blocked) begin
          if (dir == DIR_DOWN) state_nx = BACK;
          else                 do_adv   = 1'b1;
        end else begin
          mem_rd   = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (mem_dout) begin
          if (dir == DIR_DOWN) begin
            state_nx = BACK;
          end else begin
            do_adv   = 1'b1;
            state_nx = CHECK;
          end
        end else if (full) begin
          set_ovf  = 1'b1;
          state_nx = FAIL;
        end else begin
          do_push  = 1'b1;
          state_nx = cand_goal ? DONE : CHECK;
        end
      end
      BACK: begin
        if (empty) begin
          state_nx = FAIL;
        end else begin
          do_pop = 1'b1;
          if (top_data != DIR_DOWN) state_nx = CHECK;
        end
      end
      REPLAY: begin
        if (rep_last) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: a push also resets the direction scan for the new cell.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_x   <= '0;
      pos_y   <= '0;
      dir     <= DIR_UP;
      visited <= '0;
      ovf_q   <= 1'b0;
      rep_idx <= '0;
    end else begin
      if (do_clear) begin
        pos_x   <= '0;
        pos_y   <= '0;
        dir     <= DIR_UP;
        visited <= CELLS'(1);
        ovf_q   <= 1'b0;
      end
      if (do_adv) dir <= dir + 2'd1;
      if (do_push) begin
        pos_x              <= cand_x;
        pos_y              <= cand_y;
        visited[cand_addr] <= 1'b1;
        dir                <= DIR_UP;
      end
      if (do_pop) begin
        pos_x <= back_x;
        pos_y <= back_y;
        dir   <= top_data + 2'd1;
      end
      if (set_ovf) ovf_q <= 1'b1;
      if (rep_start) begin
        rep_idx <= '0;
      end else if (state == REPLAY) begin
        rep_idx <= rep_idx + SP_W'(1);
      end
    end
  end

`ifdef MAZE_STEP_CNT_EN
  logic [15:0] step_cnt;

  always_ff @(posedge clk) begin
    if (rst || do_clear) begin
      step_cnt <= '0;
    end else if ((do_push || do_pop) && (step_cnt != 16'hFFFF)) begin
      step_cnt <= step_cnt + 16'd1;
    end
  end

  assign steps = step_cnt;
`endif

  assign mem_addr   = mem_rd ? cand_addr : '0;
  assign busy       = (state == CHECK) || (state == WAIT) || (state == BACK) || (state == REPLAY);
  assign done       = (state == DONE) || (state == REPLAY);
  assign fail       = (state == FAIL);
  assign overflow   = ovf_q;
  assign move_valid = (state == REPLAY);
  assign move       = (state == REPLAY) ? rd_data : 2'd0;
  assign x_o        = pos_x;
  assign y_o        = pos_y;
  assign path_len   = sp;

endmodule

// File: tb/tb_maze_dfs_solver.sv
// Self-checking bench for maze_dfs_solver on 4x4 grids: a behavioural DFS
// model feeds a scoreboard of expected results and replay moves.
module tb_maze_dfs_solver;

  typedef struct {
    int done;
    int fail;
    int ovf;
    int plen;
    int x;
    int y;
    int cycles;
    int steps;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, run_a = 1'b0, start_b = 1'b0, run_b = 1'b0;
  logic [15:0] walls_a = '0, walls_b = '0;
  logic        mem_rd_a, mem_rd_b;
  logic        mem_dout_a, mem_dout_b;
  logic [3:0]  mem_addr_a, mem_addr_b;
  logic        busy_a, done_a, fail_a, ovf_a, mv_a;
  logic        busy_b, done_b, fail_b, ovf_b, mv_b;
  logic [1:0]  move_a, move_b, x_a, y_a, x_b, y_b;
  logic [8:0]  plen_a;
  logic [1:0]  plen_b;
`ifdef MAZE_STEP_CNT_EN
  logic [15:0] steps_a, steps_b;
`endif

  int   errors = 0;
  int   checks = 0;
  res_t m_res;
  res_t obs;
  res_t exp_q[$];
  int   model_path[$];
  int   exp_moves[$];

  maze_dfs_solver #(.X_W(2), .Y_W(2), .STACK_DEPTH(256), .SP_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .run(run_a),
    .mem_rd(mem_rd_a), .mem_addr(mem_addr_a), .mem_dout(mem_dout_a),
    .busy(busy_a), .done(done_a), .fail(fail_a), .overflow(ovf_a),
    .move(move_a), .move_valid(mv_a), .x_o(x_a), .y_o(y_a), .path_len(plen_a)
`ifdef MAZE_STEP_CNT_EN
    , .steps(steps_a)
`endif
  );

  maze_dfs_solver #(.X_W(2), .Y_W(2), .STACK_DEPTH(2), .SP_W(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .run(run_b),
    .mem_rd(mem_rd_b), .mem_addr(mem_addr_b), .mem_dout(mem_dout_b),
    .busy(busy_b), .done(done_b), .fail(fail_b), .overflow(ovf_b),
    .move(move_b), .move_valid(mv_b), .x_o(x_b), .y_o(y_b), .path_len(plen_b)
`ifdef MAZE_STEP_CNT_EN
    , .steps(steps_b)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous maze memories: wall bit appears the cycle after mem_rd.
  always @(posedge clk) begin
    if (rst) mem_dout_a <= 1'b0;
    else if (mem_rd_a) mem_dout_a <= walls_a[mem_addr_a];
  end

  always @(posedge clk) begin
    if (rst) mem_dout_b <= 1'b0;
    else if (mem_rd_b) mem_dout_b <= walls_b[mem_addr_b];
  end

  // Reference DFS on a 4x4 grid with busy-cycle and step accounting.
  task automatic model_search(input logic [15:0] walls, input int depth);
    bit vis [16];
    int stk[$];
    int px, py, d, nx, ny, mode, guard, pd;
    m_res = '{default: 0};
    foreach (vis[i]) vis[i] = 1'b0;
    px = 0; py = 0; d = 0; mode = 0; guard = 0;
    vis[0] = 1'b1;
    while (mode != 2 && guard < 10000) begin
      guard++;
      if (mode == 0) begin
        nx = (d == 1) ? px + 1 : (d == 2) ? px - 1 : px;
        ny = (d == 3) ? py + 1 : (d == 0) ? py - 1 : py;
        if (nx < 0 || nx > 3 || ny < 0 || ny > 3 || vis[ny*4+nx]) begin
          m_res.cycles++;
          if (d == 3) mode = 1; else d++;
        end else begin
          m_res.cycles += 2;
          if (walls[ny*4+nx]) begin
            if (d == 3) mode = 1; else d++;
          end else if (stk.size() == depth) begin
            m_res.fail = 1; m_res.ovf = 1; mode = 2;
          end else begin
            stk.push_back(d);
            px = nx; py = ny; vis[py*4+px] = 1'b1; d = 0;
            m_res.steps++;
            if (px == 3 && py == 3) begin m_res.done = 1; mode = 2; end
          end
        end
      end else begin
        m_res.cycles++;
        if (stk.size() == 0) begin
          m_res.fail = 1; mode = 2;
        end else begin
          pd = stk.pop_back();
          px -= (pd == 1) ? 1 : (pd == 2) ? -1 : 0;
          py -= (pd == 3) ? 1 : (pd == 0) ? -1 : 0;
          m_res.steps++;
          if (pd != 3) begin d = pd + 1; mode = 0; end
        end
      end
    end
    m_res.plen = stk.size();
    m_res.x = px;
    m_res.y = py;
    model_path = stk;
  endtask

  // Starts a search on dut_a, optionally re-pulsing start at busy cycle mid_start.
  task automatic search_a(input logic [15:0] walls, input int mid_start);
    int n;
    walls_a = walls;
    model_search(walls, 256);
    exp_q.push_back(m_res);
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    obs = '{default: 0};
    n = 0;
    while (!(done_a || fail_a) && n < 2000) begin
      if (busy_a) obs.cycles++;
      start_a = (n == mid_start) ? 1'b1 : 1'b0;
      n++;
      @(negedge clk);
    end
    start_a = 1'b0;
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("[TB] FAIL search_timeout got=no done/fail want=done or fail within 2000 cycles");
    end
    obs.done = int'(done_a);
    obs.fail = int'(fail_a);
    obs.ovf  = int'(ovf_a);
    obs.plen = int'(plen_a);
    obs.x    = int'(x_a);
    obs.y    = int'(y_a);
`ifdef MAZE_STEP_CNT_EN
    obs.steps = int'(steps_a);
`endif
  endtask

  // Replays dut_a's path, draining the expected-move scoreboard per move_valid.
  task automatic replay_a(output int revisits, output int ex, output int ey);
    bit vis [16];
    int n, e, px, py;
    foreach (vis[i]) vis[i] = 1'b0;
    px = 0; py = 0; vis[0] = 1'b1; revisits = 0;
    foreach (model_path[i]) exp_moves.push_back(model_path[i]);
    @(negedge clk); run_a = 1'b1;
    @(negedge clk); run_a = 1'b0;
    checks++;
    if (mv_a !== 1'b1) begin
      errors++;
      $display("[TB] FAIL replay_latency got=%b want=1", mv_a);
    end
    n = 0;
    while (mv_a === 1'b1 && n < 600) begin
      checks++;
      if (exp_moves.size() == 0) begin
        errors++;
        $display("[TB] FAIL replay_extra got=move %0d want=no move", move_a);
      end else begin
        e = exp_moves.pop_front();
        if (move_a !== 2'(e)) begin
          errors++;
          $display("[TB] FAIL replay_move[%0d] got=%0d want=%0d", n, move_a, e);
        end
      end
      px += (move_a == 2'd1) ? 1 : (move_a == 2'd2) ? -1 : 0;
      py += (move_a == 2'd3) ? 1 : (move_a == 2'd0) ? -1 : 0;
      if (px >= 0 && px <= 3 && py >= 0 && py <= 3) begin
        if (vis[py*4+px]) revisits++;
        vis[py*4+px] = 1'b1;
      end else begin
        revisits++;
      end
      n++;
      @(negedge clk);
    end
    checks++;
    if (exp_moves.size() != 0) begin
      errors++;
      $display("[TB] FAIL replay_count got=%0d want=%0d", n, n + exp_moves.size());
    end
    exp_moves.delete();
    checks++;
    if ({done_a, busy_a, mv_a} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL replay_return got={done,busy,mv}=%b want=100", {done_a, busy_a, mv_a});
    end
    ex = px;
    ey = py;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_a, done_a, fail_a, ovf_a, mv_a, mem_rd_a} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags_a got=%b want=000000", {busy_a, done_a, fail_a, ovf_a, mv_a, mem_rd_a});
    end
    checks++;
    if ({x_a, y_a, move_a, mem_addr_a} !== 10'b0 || plen_a !== 9'd0) begin
      errors++;
      $display("[TB] FAIL reset_data_a got=x%0d y%0d mv%0d addr%0d len%0d want=all 0", x_a, y_a, move_a, mem_addr_a, plen_a);
    end
    checks++;
    if ({busy_b, done_b, fail_b, ovf_b, mv_b, mem_rd_b, x_b, y_b, plen_b} !== 12'b0) begin
      errors++;
      $display("[TB] FAIL reset_b got=%b want=0", {busy_b, done_b, fail_b, ovf_b, mv_b, mem_rd_b, x_b, y_b, plen_b});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_a, done_a, fail_a} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL idle_after_reset got=%b want=000", {busy_a, done_a, fail_a});
    end
  endtask

  task automatic test_open_grid();
    res_t e;
    search_a(16'h0000, -1);
    e = exp_q.pop_front();
    checks++;
    if (obs.done != 1 || obs.fail != 0) begin
      errors++;
      $display("[TB] FAIL open_done got=done%0d fail%0d want=done1 fail0", obs.done, obs.fail);
    end
    checks++;
    if (obs.plen != e.plen) begin
      errors++;
      $display("[TB] FAIL open_plen got=%0d want=%0d", obs.plen, e.plen);
    end
    checks++;
    if (obs.x != 3 || obs.y != 3) begin
      errors++;
      $display("[TB] FAIL open_pos got=(%0d,%0d) want=(3,3)", obs.x, obs.y);
    end
    checks++;
    if (obs.cycles != e.cycles) begin
      errors++;
      $display("[TB] FAIL open_cycles got=%0d want=%0d", obs.cycles, e.cycles);
    end
  endtask

  task automatic test_replay();
    int rv, ex, ey;
    for (int pass = 0; pass < 2; pass++) begin
      replay_a(rv, ex, ey);
      checks++;
      if (rv != 0 || ex != 3 || ey != 3) begin
        errors++;
        $display("[TB] FAIL replay_walk[%0d] got=revisits%0d end(%0d,%0d) want=revisits0 end(3,3)", pass, rv, ex, ey);
      end
    end
  endtask

  task automatic test_walled();
    res_t e;
    search_a(16'h0012, -1);
    e = exp_q.pop_front();
    checks++;
    if (obs.fail != 1 || obs.done != 0 || obs.ovf != 0) begin
      errors++;
      $display("[TB] FAIL walled_flags got=fail%0d done%0d ovf%0d want=fail1 done0 ovf0", obs.fail, obs.done, obs.ovf);
    end
    checks++;
    if (obs.plen != 0 || obs.x != 0 || obs.y != 0) begin
      errors++;
      $display("[TB] FAIL walled_state got=len%0d (%0d,%0d) want=len0 (0,0)", obs.plen, obs.x, obs.y);
    end
    checks++;
    if (obs.cycles != e.cycles) begin
      errors++;
      $display("[TB] FAIL walled_cycles got=%0d want=%0d", obs.cycles, e.cycles);
    end
  endtask

  task automatic test_backtrack();
    res_t e;
    int rv, ex, ey;
    search_a(16'h00E0, -1);
    e = exp_q.pop_front();
    checks++;
    if (obs.done != 1 || obs.plen != e.plen) begin
      errors++;
      $display("[TB] FAIL back_result got=done%0d len%0d want=done1 len%0d", obs.done, obs.plen, e.plen);
    end
    checks++;
    if (obs.cycles != e.cycles) begin
      errors++;
      $display("[TB] FAIL back_cycles got=%0d want=%0d", obs.cycles, e.cycles);
    end
`ifdef MAZE_STEP_CNT_EN
    checks++;
    if (obs.steps != e.steps) begin
      errors++;
      $display("[TB] FAIL back_steps got=%0d want=%0d", obs.steps, e.steps);
    end
`endif
    replay_a(rv, ex, ey);
    checks++;
    if (rv != 0 || ex != 3 || ey != 3) begin
      errors++;
      $display("[TB] FAIL back_walk got=revisits%0d end(%0d,%0d) want=revisits0 end(3,3)", rv, ex, ey);
    end
  endtask

  task automatic test_overflow();
    res_t e;
    int n, cyc;
    walls_b = 16'h0000;
    model_search(16'h0000, 2);
    exp_q.push_back(m_res);
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    n = 0; cyc = 0;
    while (!(done_b || fail_b) && n < 2000) begin
      if (busy_b) cyc++;
      n++;
      @(negedge clk);
    end
    e = exp_q.pop_front();
    checks++;
    if (fail_b !== 1'b1 || ovf_b !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_flags got=fail%b ovf%b want=fail1 ovf1", fail_b, ovf_b);
    end
    checks++;
    if (int'(plen_b) != e.plen || int'(x_b) != e.x || int'(y_b) != e.y) begin
      errors++;
      $display("[TB] FAIL ovf_state got=len%0d (%0d,%0d) want=len%0d (%0d,%0d)", plen_b, x_b, y_b, e.plen, e.x, e.y);
    end
    checks++;
    if (cyc != e.cycles) begin
      errors++;
      $display("[TB] FAIL ovf_cycles got=%0d want=%0d", cyc, e.cycles);
    end
  endtask

  task automatic test_reset_mid_wait();
    res_t e;
    int n, seen;
    walls_a = 16'h0000;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    n = 0; seen = 0;
    while (n < 500) begin
      if (mem_rd_a) begin
        seen++;
        if (seen == 5) break;
      end
      n++;
      @(negedge clk);
    end
    checks++;
    if (seen != 5) begin
      errors++;
      $display("[TB] FAIL midwait_reach got=%0d reads want=5", seen);
    end
    @(negedge clk);
    checks++;
    if (mem_rd_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wait_single_rd got=rd%b busy%b want=rd0 busy1", mem_rd_a, busy_a);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy_a, done_a, fail_a, ovf_a, mv_a, mem_rd_a, x_a, y_a, move_a, mem_addr_a} !== 16'b0 || plen_a !== 9'd0) begin
      errors++;
      $display("[TB] FAIL midwait_reset got=busy%b x%0d y%0d len%0d want=all 0", busy_a, x_a, y_a, plen_a);
    end
    search_a(16'h0000, -1);
    e = exp_q.pop_front();
    checks++;
    if (obs.done != 1 || obs.plen != e.plen || obs.cycles != e.cycles) begin
      errors++;
      $display("[TB] FAIL resolve got=done%0d len%0d cyc%0d want=done1 len%0d cyc%0d", obs.done, obs.plen, obs.cycles, e.plen, e.cycles);
    end
  endtask

  task automatic test_back_to_back();
    res_t e;
    int rv, ex, ey;
    logic [15:0] w;
    // From DONE, with a start pulse during the search that must be ignored.
    search_a(16'h00E0, 4);
    e = exp_q.pop_front();
    checks++;
    if (obs.done != 1 || obs.plen != e.plen || obs.cycles != e.cycles) begin
      errors++;
      $display("[TB] FAIL ignore_start got=done%0d len%0d cyc%0d want=done1 len%0d cyc%0d", obs.done, obs.plen, obs.cycles, e.plen, e.cycles);
    end
    for (int k = 0; k < 6; k++) begin
      w = 16'($urandom & $urandom) & 16'h7FFE;
      search_a(w, -1);
      e = exp_q.pop_front();
      checks++;
      if (obs.done != e.done || obs.fail != e.fail || obs.plen != e.plen || obs.cycles != e.cycles) begin
        errors++;
        $display("[TB] FAIL rand[%0d] walls=%h got=d%0d f%0d len%0d cyc%0d want=d%0d f%0d len%0d cyc%0d",
                 k, w, obs.done, obs.fail, obs.plen, obs.cycles, e.done, e.fail, e.plen, e.cycles);
      end
      if (e.done == 1 && obs.done == 1) begin
        replay_a(rv, ex, ey);
        checks++;
        if (rv != 0 || ex != 3 || ey != 3) begin
          errors++;
          $display("[TB] FAIL rand_walk[%0d] got=revisits%0d end(%0d,%0d) want=revisits0 end(3,3)", k, rv, ex, ey);
        end
      end
    end
  endtask

  initial begin
    $display("[TB] maze_dfs_solver bench starting");
    test_reset();
    test_open_grid();
    test_replay();
    test_walled();
    test_backtrack();
    test_overflow();
    test_reset_mid_wait();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
